regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter_pkg.sv | 18 +
 rtl/regfile_write_arbiter_rr_pick.sv | 46 ++++
 rtl/regfile_write_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_write_arbiter_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);
    localparam int REG_DATA_W = 32;
    localparam int CNT_W      = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr == 5'd0;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Round-robin priority picker: rotate valids by ptr, find first, unrotate.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_oh_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_o
);

    logic [N-1:0]  rot_s;
    logic [N-1:0]  rot_oh_s;
    logic [IW-1:0] first_s;
    logic [IW:0]   pos_s;
    logic [IW:0]   sum_s;

    // Rotate so ptr sits at bit 0, pick lowest set bit, map back to requester index.
    always_comb begin
        rot_s      = '0;
        rot_oh_s   = '0;
        grant_oh_o = '0;
        first_s    = '0;
        pos_s      = '0;
        for (int i = 0; i < N; i++) begin
            pos_s    = (IW+1)'(i) + {1'b0, ptr_i};
            pos_s    = (pos_s >= (IW+1)'(N)) ? pos_s - (IW+1)'(N) : pos_s;
            rot_s[i] = valid_i[pos_s[IW-1:0]];
        end
        for (int i = N - 1; i >= 0; i--) begin
            first_s = rot_s[i] ? IW'(i) : first_s;
        end
        rot_oh_s[first_s] = |rot_s;
        for (int i = 0; i < N; i++) begin
            pos_s                       = (IW+1)'(i) + {1'b0, ptr_i};
            pos_s                       = (pos_s >= (IW+1)'(N)) ? pos_s - (IW+1)'(N) : pos_s;
            grant_oh_o[pos_s[IW-1:0]]   = rot_oh_s[i];
        end
        sum_s       = {1'b0, first_s} + {1'b0, ptr_i};
        sum_s       = (sum_s >= (IW+1)'(N)) ? sum_s - (IW+1)'(N) : sum_s;
        grant_idx_o = sum_s[IW-1:0];
        any_o       = |valid_i;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin, burst-bounded arbiter for the single register-file write port.
// Optional: define ZERO_REG_PROTECT_EN to swallow (accept but not write) writes to r0.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NREQ*REG_DATA_W-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       wr_en,
    output logic [REG_ADDR_W-1:0]      wr_addr,
    output logic [REG_DATA_W-1:0]      wr_data,
    output logic [IDW-1:0]             grant_id,
    output logic                       busy
);

    localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);

    arb_state_e            state_q, state_d;
    logic [IDW-1:0]        owner_q, owner_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [REG_DATA_W-1:0] wr_data_q, wr_data_d;

    logic [NREQ-1:0]       pick_oh_s;
    logic [IDW-1:0]        pick_idx_s;
    logic                  pick_any_s;
    logic                  can_extend_s;
    logic                  accept_s;
    logic                  zero_blk_s;
    logic [IDW-1:0]        sel_s;
    logic [REG_ADDR_W-1:0] addr_arr_s [NREQ];
    logic [REG_DATA_W-1:0] data_arr_s [NREQ];

    rr_priority_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_pick (
        .valid_i     (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_oh_o  (pick_oh_s),
        .grant_idx_o (pick_idx_s),
        .any_o       (pick_any_s)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a burst continues only while the owner keeps streaming under the cap.
    always_comb begin
        can_extend_s = req_valid[owner_q] && (burst_cnt_q < MAX_BURST_C);
        case (state_q)
            IDLE:    state_d = pick_any_s ? BURST : IDLE;
            BURST:   state_d = can_extend_s ? BURST : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: one-hot ready, forced low during reset and on the release bubble.
    always_comb begin
        req_ready = '0;
        if (reset) begin
            req_ready = '0;
        end else begin
            case (state_q)
                IDLE:    req_ready = pick_oh_s;
                BURST:   req_ready[owner_q] = can_extend_s;
                default: req_ready = '0;
            endcase
        end
        busy     = (state_q == BURST);
        grant_id = owner_q;
        wr_en    = wr_en_q;
        wr_addr  = wr_addr_q;
        wr_data  = wr_data_q;
    end

    // Unpack the requester buses for indexed selection.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr_s[i] = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
            data_arr_s[i] = req_data[i*REG_DATA_W +: REG_DATA_W];
        end
    end

    // Datapath next-state: capture accepted write, track owner, burst length and pointer.
    always_comb begin
        accept_s = |(req_ready & req_valid);
        sel_s    = (state_q == IDLE) ? pick_idx_s : owner_q;
`ifdef ZERO_REG_PROTECT_EN
        zero_blk_s = is_zero_reg(addr_arr_s[sel_s]);
`else
        zero_blk_s = 1'b0;
`endif
        wr_en_d     = accept_s && !zero_blk_s;
        wr_addr_d   = wr_en_d ? addr_arr_s[sel_s] : wr_addr_q;
        wr_data_d   = wr_en_d ? data_arr_s[sel_s] : wr_data_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    owner_d     = pick_idx_s;
                    burst_cnt_d = CNT_W'(1);
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
            end
            BURST: begin
                if (can_extend_s) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end else begin
                    rr_ptr_d    = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);
                    burst_cnt_d = '0;
                end
            end
            default: begin
                burst_cnt_d = '0;
            end
        endcase
    end

    // Datapath registers; a write captured in a reset cycle is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench: three arbiters (MAX_BURST 4, 2, 1) against a per-instance reference model.
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int ND = 3;
`ifdef ZERO_REG_PROTECT_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid [ND];
    logic [N*5-1:0] req_addr  [ND];
    logic [N*32-1:0] req_data [ND];
    logic [N-1:0]   req_ready [ND];
    logic           wr_en     [ND];
    logic [4:0]     wr_addr   [ND];
    logic [31:0]    wr_data   [ND];
    logic [1:0]     grant_id  [ND];
    logic           busy      [ND];

    always #5 clock = ~clock;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int MBG = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
        regfile_write_arbiter #(.NREQ(N), .MAX_BURST(MBG)) u_dut (
            .clock     (clock),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_addr  (req_addr[g]),
            .req_data  (req_data[g]),
            .req_ready (req_ready[g]),
            .wr_en     (wr_en[g]),
            .wr_addr   (wr_addr[g]),
            .wr_data   (wr_data[g]),
            .grant_id  (grant_id[g]),
            .busy      (busy[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who holds the port, how many writes it has had, where the next search starts.
    int          mb_tab   [ND] = '{4, 2, 1};
    int          m_holder [ND];
    int          m_cnt    [ND];
    int          m_ptr    [ND];
    int          m_gid    [ND];
    logic        e_wr     [ND];
    logic [4:0]  e_addr   [ND];
    logic [31:0] e_data   [ND];
    int          acc_last [ND];
    bit          after_rst;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int d, input logic rst);
        logic [N-1:0] v;
        logic [N-1:0] rdy;
        logic [4:0]   a;
        int           acc;
        v   = req_valid[d];
        rdy = '0;
        acc = -1;
        if (!rst) begin
            if (m_holder[d] < 0) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr[d] + k) % N;
                    if (v[idx] && rdy == '0) rdy[idx] = 1'b1;
                end
            end else if (v[m_holder[d]] && m_cnt[d] < mb_tab[d]) begin
                rdy[m_holder[d]] = 1'b1;
            end
        end
        check_val($sformatf("d%0d req_ready", d), 64'(req_ready[d]), 64'(rdy));
        for (int r = 0; r < N; r++) if (rdy[r] && v[r]) acc = r;
        if (rst) begin
            m_holder[d] = -1; m_cnt[d] = 0; m_ptr[d] = 0; m_gid[d] = 0;
            e_wr[d] = 1'b0; e_addr[d] = 5'd0; e_data[d] = 32'd0;
        end else if (acc >= 0) begin
            if (m_holder[d] < 0) begin
                m_holder[d] = acc; m_gid[d] = acc; m_cnt[d] = 1;
            end else begin
                m_cnt[d]++;
            end
            a = req_addr[d][acc*5 +: 5];
            e_wr[d] = !(ZP && a == 5'd0);
            if (e_wr[d]) begin
                e_addr[d] = a;
                e_data[d] = req_data[d][acc*32 +: 32];
            end
        end else begin
            e_wr[d] = 1'b0;
            if (m_holder[d] >= 0) begin
                m_ptr[d]    = (m_holder[d] + 1) % N;
                m_holder[d] = -1;
            end
        end
        acc_last[d] = acc;
    endtask

    // Phase table: length, requester mask, % raise, % continue after accept, % reset.
    int         ph_len   [5] = '{4, 80, 40, 30, 2000};
    logic [3:0] ph_mask  [5] = '{4'b1111, 4'b0100, 4'b0011, 4'b1000, 4'b1111};
    int         ph_raise [5] = '{100, 30, 100, 100, 50};
    int         ph_cont  [5] = '{100, 70, 100, 100, 60};
    int         ph_rst   [5] = '{0, 0, 0, 0, 2};

    initial begin
        bit   started;
        logic rst_now;
        started = 1'b0;
        for (int d = 0; d < ND; d++) begin
            req_valid[d] = '0; req_addr[d] = '0; req_data[d] = '0;
            m_holder[d] = -1; m_cnt[d] = 0; m_ptr[d] = 0; m_gid[d] = 0;
            e_wr[d] = 1'b0; e_addr[d] = 5'd0; e_data[d] = 32'd0; acc_last[d] = -1;
        end
        after_rst = 1'b0;
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < ph_len[p]; c++) begin
                @(negedge clock);
                if (started) begin
                    for (int d = 0; d < ND; d++) begin
                        check_val($sformatf("d%0d wr_en", d), 64'(wr_en[d]), 64'(e_wr[d]));
                        check_val($sformatf("d%0d wr_addr", d), 64'(wr_addr[d]), 64'(e_addr[d]));
                        check_val($sformatf("d%0d wr_data", d), 64'(wr_data[d]), 64'(e_data[d]));
                        check_val($sformatf("d%0d busy", d), 64'(busy[d]), 64'(m_holder[d] >= 0));
                        if (m_holder[d] >= 0 || after_rst)
                            check_val($sformatf("d%0d grant_id", d), 64'(grant_id[d]), 64'(m_gid[d]));
                    end
                end
                rst_now = (p == 0) || ($urandom_range(0, 99) < ph_rst[p]) || (p == 2 && c == 12);
                reset = rst_now;
                for (int d = 0; d < ND; d++) begin
                    for (int r = 0; r < N; r++) begin
                        bit go;
                        if (req_valid[d][r] && acc_last[d] != r) begin
                            go = 1'b0;
                        end else begin
                            go = ph_mask[p][r] && ($urandom_range(0, 99) <
                                 (req_valid[d][r] ? ph_cont[p] : ph_raise[p]));
                            req_valid[d][r] = go;
                            if (go) begin
                                req_addr[d][r*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0
                                                        : 5'($urandom_range(0, 31));
                                req_data[d][r*32 +: 32] = $urandom;
                            end
                        end
                    end
                end
                #1;
                for (int d = 0; d < ND; d++) model_step(d, rst_now);
                after_rst = rst_now;
                started   = 1'b1;
            end
        end
        @(negedge clock);
        for (int d = 0; d < ND; d++)
            check_val($sformatf("d%0d final wr_en", d), 64'(wr_en[d]), 64'(e_wr[d]));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
